// File: rtl/store_rmw_unit_pkg.sv
// store_rmw_unit_pkg
// Shared definitions for the store read-modify-write unit.
// - Size codes (MB_*): the same encoding the load byte/half extractor uses.
// - state_t: the FSM states of store_rmw_unit.
// - Helpers that classify a request by its size code and low address bits.
package store_rmw_unit_pkg;

    localparam logic [1:0] MB_WORD = 2'b00;
    localparam logic [1:0] MB_HALF = 2'b10;
    localparam logic [1:0] MB_BYTE = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Sub-word stores need the old word first.
    function automatic logic is_subword(input logic [1:0] mb);
        return (mb == MB_HALF) || (mb == MB_BYTE);
    endfunction

    // Bytes never misalign; halves need addr[0]=0; words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] mb, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (mb)
            MB_BYTE: bad = 1'b0;
            MB_HALF: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge
// Combinational lane merge: places the low lanes of the store data into
// the byte lane(s) selected by size and addr[1:0]; other lanes keep the
// old word. Mirror image of the load extractor.
// Ports:
//   old_word  in  32  word read back from memory
//   st_data   in  32  store data, value in the low lanes
//   mem_byte  in  2   size code (MB_BYTE / MB_HALF / others word)
//   addr_lo   in  2   byte address bits [1:0]
//   merged    out 32  word to write back
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  mem_byte,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (mem_byte)
            MB_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = st_data[7:0];
                    2'd1:    merged[15:8]  = st_data[7:0];
                    2'd2:    merged[23:16] = st_data[7:0];
                    default: merged[31:24] = st_data[7:0];
                endcase
            end
            MB_HALF: begin
                // addr[0] is not looked at: a misaligned half lands on the
                // half selected by addr[1] unless the align check rejects it.
                if (addr_lo[1]) merged[31:16] = st_data[15:0];
                else            merged[15:0]  = st_data[15:0];
            end
            default: merged = st_data;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit
// Turns sw/sh/sb requests from the MEM stage into whole-word memory writes.
// Word stores write directly; sub-word stores read the word, merge the new
// lane(s) and write it back. Every memory wait is bounded by TIMEOUT_CYC.
// Optional build macro: STORE_RMW_ALIGN_CHECK_EN -- when defined, a
// misaligned half or word store is rejected with st_err and never reaches
// memory; when undefined the low address bits that do not select a lane
// are ignored.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   st_valid/st_ready           request handshake (ready only in IDLE)
//   st_mem_byte, st_addr, st_data  request size code, byte address, data
//   st_done / st_err            one-cycle completion / abort pulses
//   mem_rd_req/addr/valid/data  word read port (req held until valid)
//   mem_wr_en/addr/data/ack     word write port (en held until ack)
//   dbg_state                   current FSM state (state_t encoding)
//
// Handshakes: a store is accepted on a rising edge where st_valid and
// st_ready are both high. mem_rd_req / mem_wr_en rise on entry to READ /
// WRITE and stay high, with stable address/data, until the cycle where
// mem_rd_valid / mem_wr_ack is sampled high or the wait times out.
// mem_rd_valid / mem_wr_ack outside those states are ignored.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        st_mem_byte,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    input  logic              mem_wr_ack,
    output logic [2:0]        dbg_state
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    // Last waiting cycle: the request has then been held TIMEOUT_CYC cycles.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

`ifdef STORE_RMW_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_t            state;
    logic [CW-1:0]     tmo_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [1:0]        mb_q;
    logic [31:0]       wr_data_q;
    logic [31:0]       merged;

    store_lane_merge u_merge (
        .old_word (mem_rd_data),
        .st_data  (data_q),
        .mem_byte (mb_q),
        .addr_lo  (addr_q[1:0]),
        .merged   (merged)
    );

    assign st_ready    = (state == IDLE);
    assign mem_rd_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wr_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wr_data = wr_data_q;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_en  <= 1'b0;
            st_done    <= 1'b0;
            st_err     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            mb_q       <= MB_WORD;
            wr_data_q  <= '0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (st_valid) begin
                        addr_q  <= st_addr;
                        data_q  <= st_data;
                        mb_q    <= st_mem_byte;
                        tmo_cnt <= '0;
                        if (ALIGN_CHECK && is_misaligned(st_mem_byte, st_addr[1:0])) begin
                            st_err <= 1'b1;
                            state  <= ERR;
                        end else if (is_subword(st_mem_byte)) begin
                            mem_rd_req <= 1'b1;
                            state      <= READ;
                        end else begin
                            wr_data_q <= st_data;
                            mem_wr_en <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                end
                READ: begin
                    // Valid takes priority over a timeout in the same cycle.
                    if (mem_rd_valid) begin
                        mem_rd_req <= 1'b0;
                        wr_data_q  <= merged;
                        mem_wr_en  <= 1'b1;
                        tmo_cnt    <= '0;
                        state      <= WRITE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_rd_req <= 1'b0;
                        tmo_cnt    <= tmo_cnt + 1'b1;
                        st_err     <= 1'b1;
                        state      <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        mem_wr_en <= 1'b0;
                        st_done   <= 1'b1;
                        state     <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_wr_en <= 1'b0;
                        tmo_cnt   <= tmo_cnt + 1'b1;
                        st_err    <= 1'b1;
                        state     <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit
// Directed bench for store_rmw_unit. The driver pushes one expected record
// per store; a monitor pops and compares it whenever st_done or st_err
// pulses. A responder process plays the word memory with per-store delays.
module tb_store_rmw_unit;
    import store_rmw_unit_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TMO    = 255;
    // record: {done, rd_seen, wr_seen, rd_addr, wr_addr, wr_data, latency}
    localparam int W = 115;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              st_valid = 1'b0;
    logic              st_ready;
    logic [1:0]        st_mem_byte = 2'b00;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [31:0]       st_data = '0;
    logic              st_done, st_err;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_valid = 1'b0;
    logic [31:0]       mem_rd_data = '0;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_wr_ack = 1'b0;
    logic [2:0]        dbg_state;

    store_rmw_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_mem_byte(st_mem_byte),
        .st_addr(st_addr), .st_data(st_data),
        .st_done(st_done), .st_err(st_err),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
        .dbg_state(dbg_state)
    );

    // ---------------- memory responder ----------------
    logic [31:0] mem_word = 32'h11223344;
    int rd_delay = 0;
    int wr_delay = 0;

    initial begin
        int rd_cnt;
        int wr_cnt;
        rd_cnt = 0;
        wr_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_rd_data = mem_word;
            if (mem_rd_req) begin
                mem_rd_valid = (rd_cnt == rd_delay);
                rd_cnt = rd_cnt + 1;
            end else begin
                mem_rd_valid = 1'b0;
                rd_cnt = 0;
            end
            if (mem_wr_en) begin
                mem_wr_ack = (wr_cnt == wr_delay);
                wr_cnt = wr_cnt + 1;
            end else begin
                mem_wr_ack = 1'b0;
                wr_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] mk(input logic done, input logic rds, input logic wrs,
                                        input logic [31:0] rda, input logic [31:0] wra,
                                        input logic [31:0] wrd, input int lat);
        logic [15:0] l;
        l = 16'(lat);
        return {done, rds, wrs, rda, wra, wrd, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor
    initial begin
        logic        rd_seen, wr_seen, chk_ready;
        logic [31:0] rd_a, wr_a, wr_d;
        logic [W-1:0] act, exp;
        int acc;
        rd_seen = 0; wr_seen = 0; chk_ready = 0;
        rd_a = '0; wr_a = '0; wr_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_seen = 0; wr_seen = 0; chk_ready = 0;
                rd_a = '0; wr_a = '0; wr_d = '0;
            end else begin
                if (chk_ready) begin
                    check("ready_after_err", 32'(st_ready), 32'd1);
                    chk_ready = 0;
                end
                if (mem_rd_req) begin
                    rd_seen = 1; rd_a = mem_rd_addr;
                end
                if (mem_wr_en) begin
                    wr_seen = 1; wr_a = mem_wr_addr; wr_d = mem_wr_data;
                end
                if (st_done || st_err) begin
                    checks = checks + 1;
                    if (exp_q.size() == 0) begin
                        errors = errors + 1;
                        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", st_done, st_err);
                    end else begin
                        exp = exp_q.pop_front();
                        acc = acc_q.pop_front();
                        act = mk(st_done, rd_seen, wr_seen, rd_a, wr_a, wr_d, cyc - acc);
                        if (act !== exp) begin
                            errors = errors + 1;
                            $display("FAIL store_result: got %h expected %h", act, exp);
                        end
                        if (st_err) chk_ready = 1;
                    end
                    rd_seen = 0; wr_seen = 0;
                    rd_a = '0; wr_a = '0; wr_d = '0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] mb, input logic [31:0] addr, input logic [31:0] data,
                         input int rdd, input int wrd, input logic track, input logic [W-1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!st_ready && n < 1000) begin
            @(negedge clk);
            n = n + 1;
        end
        if (!st_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ready_wait: got st_ready=0 expected 1 within 1000 cycles");
            return;
        end
        rd_delay = rdd;
        wr_delay = wrd;
        st_valid = 1'b1;
        st_mem_byte = mb;
        st_addr = addr;
        st_data = data;
        if (track) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(st_ready), 32'd1);
        check("rst_rd_req", 32'(mem_rd_req), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_done", 32'(st_done), 32'd0);
        check("rst_err", 32'(st_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_wr_addr", mem_wr_addr, 32'h0);
        rst_n = 1'b1;

        // sw, zero-wait ack: no read, 2-cycle latency
        issue(MB_WORD, 32'h100, 32'hDEADBEEF, 0, 0, 1, mk(1, 0, 1, 0, 32'h100, 32'hDEADBEEF, 2));
        // sb lane 3
        issue(MB_BYTE, 32'h203, 32'h000000AA, 0, 0, 1, mk(1, 1, 1, 32'h200, 32'h200, 32'hAA223344, 3));
        // sh upper / lower half
        issue(MB_HALF, 32'h302, 32'h0000BEEF, 0, 0, 1, mk(1, 1, 1, 32'h300, 32'h300, 32'hBEEF3344, 3));
        issue(MB_HALF, 32'h300, 32'h0000BEEF, 0, 0, 1, mk(1, 1, 1, 32'h300, 32'h300, 32'h1122BEEF, 3));
        // misaligned half and word
`ifdef STORE_RMW_ALIGN_CHECK_EN
        issue(MB_HALF, 32'h301, 32'h0000BEEF, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        issue(MB_WORD, 32'h507, 32'hCAFEF00D, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
`else
        issue(MB_HALF, 32'h301, 32'h0000BEEF, 0, 0, 1, mk(1, 1, 1, 32'h300, 32'h300, 32'h1122BEEF, 3));
        issue(MB_WORD, 32'h507, 32'hCAFEF00D, 0, 0, 1, mk(1, 0, 1, 0, 32'h504, 32'hCAFEF00D, 2));
`endif
        // remaining byte lanes; upper data bits must not leak
        issue(MB_BYTE, 32'h400, 32'h12345655, 0, 0, 1, mk(1, 1, 1, 32'h400, 32'h400, 32'h11223355, 3));
        issue(MB_BYTE, 32'h401, 32'hFFFFFF66, 0, 0, 1, mk(1, 1, 1, 32'h400, 32'h400, 32'h11226644, 3));
        issue(MB_BYTE, 32'h402, 32'h00000077, 0, 0, 1, mk(1, 1, 1, 32'h400, 32'h400, 32'h11773344, 3));
        // size code 2'b01 behaves as a word
        issue(2'b01, 32'h40C, 32'h01020304, 0, 0, 1, mk(1, 0, 1, 0, 32'h40C, 32'h01020304, 2));
        // write ack delayed by 3 cycles
        issue(MB_BYTE, 32'h802, 32'h0000005A, 0, 3, 1, mk(1, 1, 1, 32'h800, 32'h800, 32'h115A3344, 6));
        // read never arrives inside the window -> timeout abort
        issue(MB_BYTE, 32'h600, 32'h00000099, TMO, 0, 1, mk(0, 1, 0, 32'h600, 0, 0, TMO + 1));
        // read valid on the last waiting cycle -> completes
        issue(MB_BYTE, 32'h601, 32'h00000099, TMO - 1, 0, 1, mk(1, 1, 1, 32'h600, 32'h600, 32'h11229944, TMO + 2));
        // back-to-back word stores
        issue(MB_WORD, 32'h700, 32'h00000001, 0, 0, 1, mk(1, 0, 1, 0, 32'h700, 32'h00000001, 2));
        issue(MB_WORD, 32'h704, 32'h00000002, 0, 0, 1, mk(1, 0, 1, 0, 32'h704, 32'h00000002, 2));

        // reset while in WRITE: abandoned silently
        issue(MB_WORD, 32'h900, 32'h55555555, 0, 100000, 0, '0);
        n = 0;
        while (!mem_wr_en && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check("reset_test_in_write", 32'(mem_wr_en), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        check("midrst_ready", 32'(st_ready), 32'd1);
        check("midrst_done", 32'(st_done), 32'd0);
        check("midrst_err", 32'(st_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_state", 32'(dbg_state), 32'(IDLE));

        // one more store after the abandoned one
        issue(MB_HALF, 32'hA02, 32'h00001234, 0, 0, 1, mk(1, 1, 1, 32'hA00, 32'hA00, 32'h12343344, 3));

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
